// File: rtl/instruction_encoder_if.sv
// Field-set input and encoded-word output handshakes of instruction_encoder.
// The master is the producer of field sets and the consumer of encoded words.
interface instruction_encoder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            in_opcode;
    logic [2:0]            in_func_3;
    logic                  in_func_7_bit_6;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [31:0]           in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instruction;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_illegal;
    logic                  mem_full;

    modport master (
        output in_valid, in_opcode, in_func_3, in_func_7_bit_6, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instruction, out_addr, out_illegal, mem_full
    );

    modport slave (
        input  in_valid, in_opcode, in_func_3, in_func_7_bit_6, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instruction, out_addr, out_illegal, mem_full
    );
endinterface

// File: rtl/instruction_encoder.sv
// Assembles RV32I words from decoded fields and streams them at ascending word addresses.
// Optional macro ENC_ILLEGAL_TRAP_EN: illegal field sets are swallowed and flagged stickily.
module instruction_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input logic clk,
    input logic rst_n,
    input logic clear,
    instruction_encoder_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        LOADED = 2'b01,
        FULL   = 2'b10
    } state_t;

    function automatic logic [31:0] encode(
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic        f7b6,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        case (op)
            OP_R:      w = {1'b0, f7b6, 5'b00000, rs2, rs1, f3, rd, op};
            OP_IMM: begin
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    w = {1'b0, f7b6, 5'b00000, imm[4:0], rs1, f3, rd, op};
                end else begin
                    w = {imm[11:0], rs1, f3, rd, op};
                end
            end
            OP_LOAD:   w = {imm[11:0], rs1, f3, rd, op};
            OP_JALR:   w = {imm[11:0], rs1, 3'b000, rd, op};
            OP_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            OP_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            OP_LUI,
            OP_AUIPC:  w = {imm[31:12], rd, op};
            OP_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default:   w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic is_illegal(
        input logic [6:0] op,
        input logic [2:0] f3,
        input logic       imm0
    );
        logic bad;
        bad = 1'b0;
        case (op)
            OP_R, OP_IMM, OP_JALR, OP_AUIPC, OP_LUI: bad = 1'b0;
            OP_LOAD:   bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            OP_STORE:  bad = (f3 > 3'b010);
            OP_BRANCH: bad = (f3 == 3'b010) || (f3 == 3'b011) || imm0;
            OP_JAL:    bad = imm0;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    state_t                state_r;
    logic                  out_valid_r;
    logic                  out_illegal_r;
    logic                  mem_full_r;
    logic [31:0]           out_instruction_r;
    logic [ADDR_WIDTH-1:0] out_addr_r;

    logic        last_s;
    logic        in_ready_s;
    logic        in_hs_s;
    logic        out_hs_s;
    logic        illegal_s;
    logic [31:0] enc_s;
    logic        load_valid_s;
    logic [31:0] load_word_s;
    logic        load_illegal_s;
    logic        idle_illegal_s;

    // Handshake qualification and the word/flag a newly accepted field set produces
    always_comb begin
        last_s     = (out_addr_r == LAST_A);
        in_ready_s = !clear && !mem_full_r && (!out_valid_r || (bus.out_ready && !last_s));
        in_hs_s    = bus.in_valid && in_ready_s;
        out_hs_s   = out_valid_r && bus.out_ready;
        enc_s      = encode(bus.in_opcode, bus.in_func_3, bus.in_func_7_bit_6,
                            bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
        illegal_s  = is_illegal(bus.in_opcode, bus.in_func_3, bus.in_imm[0]);
`ifdef ENC_ILLEGAL_TRAP_EN
        // Illegal sets leave no word behind; the flag stays up until clear/reset
        load_valid_s   = !illegal_s;
        load_word_s    = enc_s;
        load_illegal_s = out_illegal_r || illegal_s;
        idle_illegal_s = out_illegal_r;
`else
        load_valid_s   = 1'b1;
        load_word_s    = illegal_s ? NOP_WORD : enc_s;
        load_illegal_s = illegal_s;
        idle_illegal_s = 1'b0;
`endif
    end

    // Output-register FSM: EMPTY / LOADED / FULL with address sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= EMPTY;
            out_valid_r       <= 1'b0;
            out_instruction_r <= 32'h0000_0000;
            out_illegal_r     <= 1'b0;
            out_addr_r        <= BASE_A;
            mem_full_r        <= 1'b0;
        end else if (clear) begin
            state_r           <= EMPTY;
            out_valid_r       <= 1'b0;
            out_instruction_r <= 32'h0000_0000;
            out_illegal_r     <= 1'b0;
            out_addr_r        <= BASE_A;
            mem_full_r        <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_hs_s) begin
                        out_valid_r       <= load_valid_s;
                        out_instruction_r <= load_word_s;
                        out_illegal_r     <= load_illegal_s;
                        state_r           <= load_valid_s ? LOADED : EMPTY;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                LOADED: begin
                    if (out_hs_s && last_s) begin
                        state_r       <= FULL;
                        out_valid_r   <= 1'b0;
                        out_illegal_r <= idle_illegal_s;
                        mem_full_r    <= 1'b1;
                    end else if (out_hs_s) begin
                        out_addr_r <= out_addr_r + ADDR_WIDTH'(1);
                        if (in_hs_s) begin
                            out_valid_r       <= load_valid_s;
                            out_instruction_r <= load_word_s;
                            out_illegal_r     <= load_illegal_s;
                            state_r           <= load_valid_s ? LOADED : EMPTY;
                        end else begin
                            out_valid_r   <= 1'b0;
                            out_illegal_r <= idle_illegal_s;
                            state_r       <= EMPTY;
                        end
                    end else begin
                        state_r <= LOADED;
                    end
                end
                FULL: begin
                    state_r <= FULL;
                end
                default: begin
                    state_r     <= EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready        = in_ready_s;
    assign bus.out_valid       = out_valid_r;
    assign bus.out_instruction = out_instruction_r;
    assign bus.out_addr        = out_addr_r;
    assign bus.out_illegal     = out_illegal_r;
    assign bus.mem_full        = mem_full_r;
endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized bench for instruction_encoder with an in-bench word-stream reference model.
module tb_instruction_encoder;
    localparam int AW   = 2;
    localparam int BASE = 0;
    localparam int LAST = (1 << AW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    instruction_encoder_if #(.ADDR_WIDTH(AW)) bus ();

    instruction_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: at most one word waiting for the loader
    bit          m_pend;
    int unsigned m_word;
    int          m_addr;
    bit          m_ill;
    int          m_next;
    bit          m_full;
    bit          m_sticky;

`ifdef ENC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned ref_encode(input int unsigned op, input int unsigned f3,
            input int unsigned f7, input int unsigned rd, input int unsigned rs1,
            input int unsigned rs2, input int unsigned imm);
        int unsigned base_r;
        base_r = (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        case (op)
            32'h33: return (f7 << 30) | (rs2 << 20) | base_r;
            32'h13: begin
                if (f3 == 32'd1 || f3 == 32'd5) return (f7 << 30) | ((imm & 32'h1f) << 20) | base_r;
                else return ((imm & 32'hfff) << 20) | base_r;
            end
            32'h03: return ((imm & 32'hfff) << 20) | base_r;
            32'h67: return ((imm & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | op;
            32'h23: return (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                           | ((imm & 32'h1f) << 7) | op;
            32'h63: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20)
                           | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hf) << 8)
                           | (((imm >> 11) & 32'h1) << 7) | op;
            32'h37, 32'h17: return (imm & 32'hfffff000) | (rd << 7) | op;
            32'h6f: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                           | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hff) << 12)
                           | (rd << 7) | op;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_illegal(input int unsigned op, input int unsigned f3, input int unsigned imm);
        case (op)
            32'h33, 32'h13, 32'h67, 32'h17, 32'h37: return 1'b0;
            32'h03: return (f3 == 32'd3) || (f3 >= 32'd6);
            32'h23: return f3 > 32'd2;
            32'h63: return (f3 == 32'd2) || (f3 == 32'd3) || ((imm & 32'h1) != 32'h0);
            32'h6f: return (imm & 32'h1) != 32'h0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit exp_in_ready();
        if (clear) return 1'b0;
        return !m_full && (!m_pend || (bus.out_ready && m_addr != LAST));
    endfunction

    task automatic model_reset();
        m_pend = 1'b0; m_word = 0; m_addr = BASE; m_ill = 1'b0;
        m_next = BASE; m_full = 1'b0; m_sticky = 1'b0;
    endtask

    // compare DUT against the model for the current cycle, then apply the coming edge
    task automatic tick();
        bit rdy, ohs, ihs, ill;
        int unsigned w;
        #1;
        rdy = exp_in_ready();
        chk("in_ready", bus.in_ready, rdy);
        chk("out_valid", bus.out_valid, m_pend);
        chk("mem_full", bus.mem_full, m_full);
        chk("out_illegal", bus.out_illegal, TRAP ? m_sticky : (m_pend && m_ill));
        if (m_pend) begin
            chk("out_instruction", bus.out_instruction, m_word);
            chk("out_addr", bus.out_addr, m_addr);
        end
        if (clear) begin
            model_reset();
        end else begin
            ohs = m_pend && bus.out_ready;
            ihs = bus.in_valid && rdy;
            if (ohs) begin
                m_pend = 1'b0;
                if (m_addr == LAST) m_full = 1'b1;
                else m_next = m_addr + 1;
            end
            if (ihs) begin
                ill = ref_illegal(bus.in_opcode, bus.in_func_3, bus.in_imm);
                w   = ref_encode(bus.in_opcode, bus.in_func_3, bus.in_func_7_bit_6,
                                 bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
                if (TRAP && ill) begin
                    m_sticky = 1'b1;
                end else begin
                    m_pend = 1'b1;
                    m_word = ill ? 32'h0000_0013 : w;
                    m_addr = m_next;
                    m_ill  = ill;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic f7,
            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
            input logic [31:0] imm, input logic ordy);
        bus.in_valid = v; bus.in_opcode = op; bus.in_func_3 = f3; bus.in_func_7_bit_6 = f7;
        bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm; bus.out_ready = ordy;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 7'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, ordy);
    endtask

    task automatic do_clear();
        clear = 1'b1; idle(1'b1); tick(); clear = 1'b0;
        chk("clear_addr", bus.out_addr, BASE);
        chk("clear_valid", bus.out_valid, 1'b0);
    endtask

    logic [6:0] ops [0:9];

    initial begin
        ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6f, 7'h7f};
        idle(1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_instr", bus.out_instruction, 32'h0);
        chk("rst_illegal", bus.out_illegal, 1'b0);
        chk("rst_addr", bus.out_addr, BASE);
        chk("rst_full", bus.mem_full, 1'b0);
        rst_n = 1'b1;

        // model pins against hand-computed words
        chk("ref_add", ref_encode(32'h33, 0, 0, 3, 1, 2, 0), 32'h002081B3);
        chk("ref_sub", ref_encode(32'h33, 0, 1, 3, 1, 2, 0), 32'h402081B3);
        chk("ref_srai", ref_encode(32'h13, 5, 1, 5, 5, 0, 3), 32'h4032D293);
        chk("ref_beq", ref_encode(32'h63, 0, 0, 0, 1, 2, 32'hFFFFFFF8), 32'hFE208CE3);
        chk("ref_lui", ref_encode(32'h37, 0, 0, 1, 0, 0, 32'h12345000), 32'h123450B7);

        // add x3,x1,x2
        drive(1'b1, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1); tick();
        chk("add_word", bus.out_instruction, 32'h002081B3);
        chk("add_addr", bus.out_addr, 0);
        idle(1'b1); tick();

        // sub then srai back to back
        do_clear();
        drive(1'b1, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1); tick();
        chk("sub_word", bus.out_instruction, 32'h402081B3);
        chk("sub_addr", bus.out_addr, 0);
        drive(1'b1, 7'h13, 3'd5, 1'b1, 5'd5, 5'd5, 5'd0, 32'd3, 1'b1); tick();
        chk("srai_word", bus.out_instruction, 32'h4032D293);
        chk("srai_addr", bus.out_addr, 1);
        idle(1'b1); tick();

        // beq held under back-pressure
        do_clear();
        drive(1'b1, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'h33, 3'd0, 1'b0, 5'd9, 5'd9, 5'd9, 32'h0, 1'b0); tick();
            chk("beq_hold_word", bus.out_instruction, 32'hFE208CE3);
            chk("beq_hold_addr", bus.out_addr, 0);
            chk("beq_hold_rdy", bus.in_ready, 1'b0);
        end
        idle(1'b1); tick();

        // fill all 2^AW words with lui, fifth held off
        do_clear();
        drive(1'b1, 7'h37, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lui_word", bus.out_instruction, 32'h123450B7);
            chk("lui_addr", bus.out_addr, i);
        end
        tick();
        chk("full_flag", bus.mem_full, 1'b1);
        chk("full_valid", bus.out_valid, 1'b0);
        chk("full_rdy", bus.in_ready, 1'b0);
        tick(); tick();
        clear = 1'b1; tick(); clear = 1'b0;
        tick();
        chk("refill_addr", bus.out_addr, 0);
        chk("refill_valid", bus.out_valid, 1'b1);
        idle(1'b1); tick();

        // unknown opcode
        do_clear();
        drive(1'b1, 7'h7f, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1); tick();
        chk("illegal_flag", bus.out_illegal, 1'b1);
        chk("illegal_valid", bus.out_valid, TRAP ? 1'b0 : 1'b1);
        if (!TRAP) chk("illegal_nop", bus.out_instruction, 32'h00000013);
        drive(1'b1, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1); tick();
        tick();
        chk("illegal_after", bus.out_illegal, TRAP ? 1'b1 : 1'b0);
        do_clear();
        chk("illegal_cleared", bus.out_illegal, 1'b0);

        // asynchronous reset with a word pending
        drive(1'b1, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0); tick();
        idle(1'b0); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 1'b0);
        chk("arst_addr", bus.out_addr, BASE);
        chk("arst_instr", bus.out_instruction, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [6:0]  op;
            logic [31:0] imm;
            op  = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 19) == 0) op = 7'($urandom);
            imm = $urandom;
            if ($urandom_range(0, 3) == 0) imm = 32'($signed(12'($urandom)));
            if ((op == 7'h63 || op == 7'h6f) && $urandom_range(0, 7) != 0) imm[0] = 1'b0;
            drive($urandom_range(0, 3) != 0, op, 3'($urandom), 1'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), imm, $urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 63) == 0);
            tick();
        end
        clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
